// File: rtl/opti_pkg.sv
// Shared constants and the saturating power-of-two gain helper for the
// IIR output stage.
package opti_pkg;

  localparam int DATA_W = 24;
  localparam int GAIN_W = 3;
  localparam int WIDE_W = DATA_W + 7;

  localparam logic signed [WIDE_W-1:0] SAMP_MAX =
    {{(WIDE_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAMP_MIN =
    {{(WIDE_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              clip;
  } sat_res_t;

  // Shift at full width (7 guard bits cover the largest gain), then clamp.
  function automatic sat_res_t sat_shl(input logic [DATA_W-1:0] s,
                                       input logic [GAIN_W-1:0] sh);
    logic signed [WIDE_W-1:0] w;
    sat_res_t r;
    w = $signed({{(WIDE_W-DATA_W){s[DATA_W-1]}}, s}) <<< sh;
    r.clip = 1'b1;
    if (w > SAMP_MAX)      r.val = SAMP_MAX[DATA_W-1:0];
    else if (w < SAMP_MIN) r.val = SAMP_MIN[DATA_W-1:0];
    else begin
      r.val  = w[DATA_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/opti_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy from extra-bit
// write/read counters so full and empty are unambiguous.
module opti_sync_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_cnt, rd_cnt;
  logic              do_wr, do_rd;

  assign level = wr_cnt - rd_cnt;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_rd = rd_en & ~empty;
  // A write into a full FIFO is accepted only when a read frees a slot
  assign do_wr = wr_en & (~full | do_rd);

  // Zero while empty so the head port never shows stale or unknown data
  assign rd_data = empty ? '0 : mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_wr) wr_cnt <= wr_cnt + 1'b1;
      if (do_rd) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_cnt[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/opti_out_buf.sv
// IIR output stage: registered saturating gain, FWFT buffer onto a
// ready/valid stream, plus drop counter and clip flag for firmware.
module opti_out_buf
  import opti_pkg::*;
#(
  parameter int DATA_W = opti_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int OVF_W  = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [2:0]        gain_sh,
  input  logic              clr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LW-1:0]     level,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              clip_sticky
);

  sat_res_t          sr;
  logic [DATA_W-1:0] y;
  logic              g_valid;
  logic              full, empty, rd_en, drop;

  assign sr = sat_shl(data_in, gain_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y           <= '0;
      g_valid     <= 1'b0;
      clip_sticky <= 1'b0;
    end else begin
      g_valid <= valid_in;
      if (valid_in) y <= sr.val;
      // A clip in the clear cycle must not be lost
      if (valid_in && sr.clip) clip_sticky <= 1'b1;
      else if (clr)            clip_sticky <= 1'b0;
    end
  end

  opti_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (g_valid),
    .wr_data (y),
    .rd_en   (rd_en),
    .rd_data (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign m_valid = ~empty;
  assign rd_en   = m_valid & m_ready;
  assign drop    = g_valid & full & ~rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (clr)           ovf_cnt <= OVF_W'(1);
      else if (~&ovf_cnt) ovf_cnt <= ovf_cnt + 1'b1;
    end else if (clr) begin
      ovf_cnt <= '0;
    end
  end

endmodule
